// File: rtl/uart_cmd_pkg.sv
// Shared types and widths for the UART host-command link controller.
package uart_cmd_pkg;

    localparam int unsigned CMD_W     = 24;
    localparam int unsigned RESP_W    = 16;
    localparam int unsigned CMD_BYTES = 3;

    typedef enum logic [2:0] {
        IDLE,
        SEND_HI,
        WAIT_HI,
        SEND_LO,
        WAIT_LO,
        DONE
    } tx_state_t;

endpackage

// File: rtl/uart_resp_tx.sv
// Response serialiser: latches a 16-bit response and hands it to the UART one byte at a time,
// MSB first, waiting for tx_done between bytes.
module uart_resp_tx
    import uart_cmd_pkg::*;
#(
    parameter int unsigned RESP_BYTES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [RESP_W-1:0] i_resp,
    input  logic              i_send_resp,
    input  logic              i_tx_done,
    output logic              o_trmt,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_busy,
    output logic              o_resp_sent
);

    tx_state_t  r_state;
    logic [7:0] r_lo_lat;
    logic       r_blank;
    logic       r_trmt;
    logic [7:0] r_tx_data;
    logic       r_tx_busy;
    logic       r_resp_sent;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_lo_lat    <= 8'h00;
            r_blank     <= 1'b0;
            r_trmt      <= 1'b0;
            r_tx_data   <= 8'h00;
            r_tx_busy   <= 1'b0;
            r_resp_sent <= 1'b0;
        end else begin
            r_trmt      <= 1'b0;
            r_resp_sent <= 1'b0;
            case (r_state)
                IDLE: begin
                    // The high byte goes straight to tx_data; only the low byte needs holding.
                    if (i_send_resp) begin
                        r_lo_lat  <= i_resp[7:0];
                        r_tx_busy <= 1'b1;
                        r_trmt    <= 1'b1;
                        if (RESP_BYTES == 2) begin
                            r_state   <= SEND_HI;
                            r_tx_data <= i_resp[15:8];
                        end else begin
                            r_state   <= SEND_LO;
                            r_tx_data <= i_resp[7:0];
                        end
                    end
                end
                SEND_HI: begin
                    r_state <= WAIT_HI;
                    r_blank <= 1'b1;
                end
                WAIT_HI: begin
                    // tx_done may still be high from the previous byte; skip one cycle.
                    if (r_blank) begin
                        r_blank <= 1'b0;
                    end else if (i_tx_done) begin
                        r_state   <= SEND_LO;
                        r_trmt    <= 1'b1;
                        r_tx_data <= r_lo_lat;
                    end
                end
                SEND_LO: begin
                    r_state <= WAIT_LO;
                    r_blank <= 1'b1;
                end
                WAIT_LO: begin
                    if (r_blank) begin
                        r_blank <= 1'b0;
                    end else if (i_tx_done) begin
                        r_state     <= DONE;
                        r_resp_sent <= 1'b1;
                    end
                end
                DONE: begin
                    r_state   <= IDLE;
                    r_tx_busy <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_trmt      = r_trmt;
    assign o_tx_data   = r_tx_data;
    assign o_tx_busy   = r_tx_busy;
    assign o_resp_sent = r_resp_sent;

endmodule

// File: rtl/uart_cmd_ctrl.sv
// UART command link: assembles 3 rx bytes into a 24-bit command and sends 16-bit responses.
// Define UART_CMD_TIMEOUT_EN to drop partial commands after TIMEOUT_CYC idle cycles.
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 1_000_000,
    parameter int unsigned RESP_BYTES  = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_rx_rdy,
    input  logic [7:0]        i_rx_data,
    output logic              o_clr_rx_rdy,
    input  logic              i_tx_done,
    output logic              o_trmt,
    output logic [7:0]        o_tx_data,
    output logic [CMD_W-1:0]  o_cmd,
    output logic              o_cmd_rdy,
    input  logic              i_clr_cmd_rdy,
    input  logic [RESP_W-1:0] i_resp,
    input  logic              i_send_resp,
    output logic              o_tx_busy,
    output logic              o_resp_sent
);

    logic [CMD_W-1:0] r_cmd;
    logic             r_cmd_rdy;
    logic [1:0]       r_byte_cnt;
    logic             w_accept;
    logic             w_timeout;
    logic [1:0]       w_cnt_eff;

    assign w_accept     = i_rx_rdy & ~r_cmd_rdy;
    assign o_clr_rx_rdy = w_accept;

`ifdef UART_CMD_TIMEOUT_EN
    logic [31:0] r_gap;

    assign w_timeout = (r_byte_cnt != 2'd0) && !r_cmd_rdy
                       && (r_gap == 32'(TIMEOUT_CYC - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_gap <= 32'd0;
        end else if (w_accept || w_timeout || r_byte_cnt == 2'd0 || r_cmd_rdy) begin
            r_gap <= 32'd0;
        end else begin
            r_gap <= r_gap + 32'd1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // A byte arriving on the timeout cycle starts a fresh command.
    assign w_cnt_eff = w_timeout ? 2'd0 : r_byte_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cmd      <= '0;
            r_cmd_rdy  <= 1'b0;
            r_byte_cnt <= 2'd0;
        end else begin
            if (r_cmd_rdy && i_clr_cmd_rdy) begin
                r_cmd_rdy <= 1'b0;
            end
            if (w_accept) begin
                case (w_cnt_eff)
                    2'd0:    r_cmd[23:16] <= i_rx_data;
                    2'd1:    r_cmd[15:8]  <= i_rx_data;
                    default: r_cmd[7:0]   <= i_rx_data;
                endcase
                if (w_cnt_eff == 2'(CMD_BYTES - 1)) begin
                    r_byte_cnt <= 2'd0;
                    r_cmd_rdy  <= 1'b1;
                end else begin
                    r_byte_cnt <= w_cnt_eff + 2'd1;
                end
            end else if (w_timeout) begin
                r_byte_cnt <= 2'd0;
            end
        end
    end

    assign o_cmd     = r_cmd;
    assign o_cmd_rdy = r_cmd_rdy;

    uart_resp_tx #(
        .RESP_BYTES(RESP_BYTES)
    ) u_resp_tx (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_resp      (i_resp),
        .i_send_resp (i_send_resp),
        .i_tx_done   (i_tx_done),
        .o_trmt      (o_trmt),
        .o_tx_data   (o_tx_data),
        .o_tx_busy   (o_tx_busy),
        .o_resp_sent (o_resp_sent)
    );

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl: expected commands/tx bytes queued by stimulus,
// checked by a negedge monitor.
module tb_uart_cmd_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        clr_rx_rdy;
    logic        tx_done;
    logic        trmt;
    logic [7:0]  tx_data;
    logic [23:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [15:0] resp;
    logic        send_resp;
    logic        tx_busy;
    logic        resp_sent;

    int total = 0;
    int bad   = 0;
    int nbytes = 0;
    int nclr = 0;
    int exp_sent = 0;
    int got_sent = 0;
    logic stale_mode = 1'b0;
    logic prev_cmd_rdy = 1'b0;
    logic [23:0] exp_cmd_q[$];
    logic [7:0]  exp_tx_q[$];

    always #5 clk = ~clk;

    uart_cmd_ctrl #(
        .TIMEOUT_CYC(50),
        .RESP_BYTES (2)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_rx_rdy     (rx_rdy),
        .i_rx_data    (rx_data),
        .o_clr_rx_rdy (clr_rx_rdy),
        .i_tx_done    (tx_done),
        .o_trmt       (trmt),
        .o_tx_data    (tx_data),
        .o_cmd        (cmd),
        .o_cmd_rdy    (cmd_rdy),
        .i_clr_cmd_rdy(clr_cmd_rdy),
        .i_resp       (resp),
        .i_send_resp  (send_resp),
        .o_tx_busy    (tx_busy),
        .o_resp_sent  (resp_sent)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: event occurred, none expected", name);
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            if (clr_rx_rdy) nclr++;
            if (cmd_rdy && !prev_cmd_rdy) begin
                if (exp_cmd_q.size() == 0) fail_now("unexpected cmd_rdy");
                else chk("cmd", cmd, exp_cmd_q.pop_front());
            end
            if (trmt) begin
                if (exp_tx_q.size() == 0) fail_now("unexpected trmt");
                else chk("tx_data", tx_data, exp_tx_q.pop_front());
            end
            if (resp_sent) begin
                got_sent++;
                chk("bytes pending at resp_sent", exp_tx_q.size(), 0);
            end
        end
        prev_cmd_rdy = cmd_rdy;
    end

    // UART transmitter model: tx_done drops on trmt and returns 10 cycles later
    initial begin
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (stale_mode) begin
                tx_done = 1'b1;
            end else if (trmt) begin
                tx_done = 1'b0;
                repeat (10) @(negedge clk);
                tx_done = 1'b1;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic ok;
        @(posedge clk); #1;
        rx_rdy  = 1'b1;
        rx_data = b;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (clr_rx_rdy) ok = 1'b1;
        end
        @(posedge clk); #1;
        rx_rdy = 1'b0;
        if (!ok) chk("rx accept timeout", 0, 1);
        nbytes++;
        repeat (gap) @(posedge clk);
    endtask

    task automatic clear_cmd();
        @(posedge clk); #1 clr_cmd_rdy = 1'b1;
        @(posedge clk); #1 clr_cmd_rdy = 1'b0;
        @(negedge clk);
        chk("cmd_rdy after clear", cmd_rdy, 0);
    endtask

    task automatic wait_resp_sent(input int limit);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (resp_sent) seen = 1'b1;
        end
        chk("resp_sent seen", seen, 1);
        @(negedge clk);
        chk("tx_busy low after resp_sent", tx_busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_trmt;
        int first_t;
        int second_t;
        rst = 1'b1; rx_rdy = 1'b0; rx_data = 8'h00; clr_cmd_rdy = 1'b0;
        resp = 16'h0000; send_resp = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst cmd", cmd, 0);
        chk("rst cmd_rdy", cmd_rdy, 0);
        chk("rst trmt", trmt, 0);
        chk("rst tx_data", tx_data, 0);
        chk("rst tx_busy", tx_busy, 0);
        chk("rst resp_sent", resp_sent, 0);
        chk("rst clr_rx_rdy", clr_rx_rdy, 0);
        @(posedge clk); #1 rst = 1'b0;

        // Basic assembly
        exp_cmd_q.push_back(24'hA51234);
        send_byte(8'hA5, 3);
        send_byte(8'h12, 5);
        send_byte(8'h34, 0);
        @(negedge clk);
        chk("cmd_rdy after byte 3", cmd_rdy, 1);
        chk("clr_rx_rdy pulses", nclr, nbytes);

        // Backpressure while cmd_rdy held; clear wins over same-cycle rx_rdy
        exp_cmd_q.push_back(24'h556677);
        @(posedge clk); #1 rx_rdy = 1'b1; rx_data = 8'h55;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("held clr_rx_rdy", clr_rx_rdy, 0);
            chk("held cmd", cmd, 24'hA51234);
        end
        @(posedge clk); #1 clr_cmd_rdy = 1'b1;
        @(negedge clk);
        chk("clear-wins clr_rx_rdy", clr_rx_rdy, 0);
        @(posedge clk); #1 clr_cmd_rdy = 1'b0;
        @(negedge clk);
        chk("cmd_rdy cleared", cmd_rdy, 0);
        chk("byte accepted after clear", clr_rx_rdy, 1);
        @(posedge clk); #1 rx_rdy = 1'b0;
        nbytes++;
        send_byte(8'h66, 2);
        send_byte(8'h77, 0);
        clear_cmd();

        // Response 0xBEEF, with an ignored second send_resp mid-flight
        exp_tx_q.push_back(8'hBE);
        exp_tx_q.push_back(8'hEF);
        exp_sent++;
        @(posedge clk); #1 resp = 16'hBEEF; send_resp = 1'b1;
        @(posedge clk); #1 send_resp = 1'b0; resp = 16'h0000;
        @(negedge clk);
        chk("tx_busy after send_resp", tx_busy, 1);
        chk("trmt latency", trmt, 1);
        repeat (4) @(posedge clk);
        #1 resp = 16'h1111; send_resp = 1'b1;
        @(posedge clk); #1 send_resp = 1'b0;
        wait_resp_sent(100);

        // Stale tx_done held high: blanking cycle must separate the two trmts
        stale_mode = 1'b1;
        @(negedge clk);
        exp_tx_q.push_back(8'hCA);
        exp_tx_q.push_back(8'hFE);
        exp_sent++;
        @(posedge clk); #1 resp = 16'hCAFE; send_resp = 1'b1;
        @(posedge clk); #1 send_resp = 1'b0;
        n_trmt = 0; first_t = 0; second_t = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (trmt) begin
                if (n_trmt == 0) first_t = i;
                else second_t = i;
                n_trmt++;
            end
        end
        chk("stale trmt count", n_trmt, 2);
        chk("stale trmt spacing", second_t - first_t, 3);
        chk("stale tx_busy idle", tx_busy, 0);
        stale_mode = 1'b0;

        // Inter-byte gap
`ifdef UART_CMD_TIMEOUT_EN
        exp_cmd_q.push_back(24'h020304);
        send_byte(8'h01, 60);
        send_byte(8'h02, 1);
        send_byte(8'h03, 1);
        send_byte(8'h04, 0);
`else
        exp_cmd_q.push_back(24'h010203);
        send_byte(8'h01, 60);
        send_byte(8'h02, 1);
        send_byte(8'h03, 0);
`endif
        @(negedge clk);
        chk("cmd_rdy after gap", cmd_rdy, 1);
        clear_cmd();

        // Reset mid-frame discards partial command
        send_byte(8'hAA, 1);
        send_byte(8'hBB, 1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("mid rst cmd_rdy", cmd_rdy, 0);
        chk("mid rst cmd", cmd, 0);
        exp_cmd_q.push_back(24'h102030);
        send_byte(8'h10, 1);
        send_byte(8'h20, 1);
        send_byte(8'h30, 0);
        @(negedge clk);
        chk("cmd_rdy after reset frame", cmd_rdy, 1);
        clear_cmd();

        repeat (5) @(posedge clk);
        chk("cmd queue drained", exp_cmd_q.size(), 0);
        chk("tx queue drained", exp_tx_q.size(), 0);
        chk("total clr_rx_rdy pulses", nclr, nbytes);
        chk("resp_sent pulses", got_sent, exp_sent);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
